// File: rtl/alu_collect_pkg.sv
// Shared types, ALU command encodings and the operand-need decoder for the ALU operand collector.
`ifndef WIDTH
`define WIDTH 8
`endif

package alu_collect_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      WAIT  = ST_WAIT,
      ISSUE = ST_ISSUE
   } state_t;

   localparam logic [3:0] A_ADD       = 4'd0;
   localparam logic [3:0] A_SUB       = 4'd1;
   localparam logic [3:0] A_ADD_CIN   = 4'd2;
   localparam logic [3:0] A_SUB_CIN   = 4'd3;
   localparam logic [3:0] A_INC_A     = 4'd4;
   localparam logic [3:0] A_DEC_A     = 4'd5;
   localparam logic [3:0] A_INC_B     = 4'd6;
   localparam logic [3:0] A_DEC_B     = 4'd7;
   localparam logic [3:0] A_CMP       = 4'd8;
   localparam logic [3:0] A_MUL_INC   = 4'd9;
   localparam logic [3:0] A_MUL_SHIFT = 4'd10;

   localparam logic [3:0] L_AND     = 4'd0;
   localparam logic [3:0] L_NAND    = 4'd1;
   localparam logic [3:0] L_OR      = 4'd2;
   localparam logic [3:0] L_NOR     = 4'd3;
   localparam logic [3:0] L_XOR     = 4'd4;
   localparam logic [3:0] L_XNOR    = 4'd5;
   localparam logic [3:0] L_NOT_A   = 4'd6;
   localparam logic [3:0] L_NOT_B   = 4'd7;
   localparam logic [3:0] L_SHR1_A  = 4'd8;
   localparam logic [3:0] L_SHL1_A  = 4'd9;
   localparam logic [3:0] L_SHR1_B  = 4'd10;
   localparam logic [3:0] L_SHL1_B  = 4'd11;
   localparam logic [3:0] L_ROL_A_B = 4'd12;
   localparam logic [3:0] L_ROR_A_B = 4'd13;

   // Undefined commands ask for both operands so the ALU itself reports the error.
   function automatic logic [1:0] op_needs(input logic mode, input logic [3:0] cmd);
      logic [1:0] need;
      need = 2'b11;
      if (mode) begin
         case (cmd)
            A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN,
            A_CMP, A_MUL_INC, A_MUL_SHIFT:          need = 2'b11;
            A_INC_A, A_DEC_A:                       need = 2'b01;
            A_INC_B, A_DEC_B:                       need = 2'b10;
            default:                                need = 2'b11;
         endcase
      end else begin
         case (cmd)
            L_AND, L_NAND, L_OR, L_NOR, L_XOR,
            L_XNOR, L_ROL_A_B, L_ROR_A_B:           need = 2'b11;
            L_NOT_A, L_SHR1_A, L_SHL1_A:            need = 2'b01;
            L_NOT_B, L_SHR1_B, L_SHL1_B:            need = 2'b10;
            default:                                need = 2'b11;
         endcase
      end
      return need;
   endfunction

endpackage

// File: rtl/alu_collect_timer.sv
// WAIT-state timeout counter: clears on request, counts ticks, flags the tick that completes CYCLES.
module alu_collect_timer
#(
   parameter int unsigned CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic tick_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = {CW{1'b0}};
      end else if (tick_i) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign expired_o = tick_i & ~clear_i & (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_operand_collector.sv
// Merges split-operand beats into complete ALU operations and issues them from registers.
// Optional partial issue after a WAIT timeout is enabled by defining ALU_COLLECT_TIMEOUT_EN.
`ifndef WIDTH
`define WIDTH 8
`endif

module alu_operand_collector
   import alu_collect_pkg::*;
#(
   parameter int unsigned WIDTH          = `WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [3:0]       in_cmd,
   input  logic             in_cin,
   input  logic [1:0]       in_inp_valid,
   input  logic [WIDTH-1:0] in_opa,
   input  logic [WIDTH-1:0] in_opb,
   input  logic             alu_ready,
   output logic             alu_ce,
   output logic             alu_mode,
   output logic [3:0]       alu_cmd,
   output logic             alu_cin,
   output logic [1:0]       alu_inp_valid,
   output logic [WIDTH-1:0] alu_opa,
   output logic [WIDTH-1:0] alu_opb,
   output logic             drop,
   output logic             timeout,
   output logic             busy
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t state_q, state_d;
   logic             mode_q, mode_d, cin_q, cin_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [1:0]       have_q, have_d;
   logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;

   logic             ce_q, busy_q, drop_q, drop_d;
   logic             iss_mode_q, iss_cin_q;
   logic [3:0]       iss_cmd_q;
   logic [1:0]       iss_vld_q;
   logic [WIDTH-1:0] iss_opa_q, iss_opb_q;

   logic       beat_s, same_s, expired_s;
   logic       start_s, merge_s, partial_s, go_idle_s;
   logic       complete_s, iss_load_s;
   logic [1:0] need_s, iss_mask_s;

   assign in_ready = rst & ((state_q != ISSUE) | alu_ready);
   // Beats carrying no operand are accepted but have no effect at all.
   assign beat_s   = in_valid & in_ready & (in_inp_valid != 2'b00);
   assign same_s   = (in_mode == mode_q) & (in_cmd == cmd_q);

   always_comb begin
      start_s   = 1'b0;
      merge_s   = 1'b0;
      partial_s = 1'b0;
      go_idle_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (beat_s) start_s = 1'b1;
            else        start_s = 1'b0;
         end
         WAIT: begin
            if (beat_s & same_s) merge_s   = 1'b1;
            else if (beat_s)     start_s   = 1'b1;
            else if (expired_s)  partial_s = 1'b1;
            else                 merge_s   = 1'b0;
         end
         ISSUE: begin
            if (alu_ready & beat_s) start_s   = 1'b1;
            else if (alu_ready)     go_idle_s = 1'b1;
            else                    go_idle_s = 1'b0;
         end
         default: go_idle_s = 1'b1;
      endcase
   end

   assign drop_d = (state_q == WAIT) & start_s;

   always_comb begin
      mode_d = mode_q;
      cmd_d  = cmd_q;
      cin_d  = cin_q;
      have_d = have_q;
      opa_d  = opa_q;
      opb_d  = opb_q;
      if (start_s) begin
         mode_d = in_mode;
         cmd_d  = in_cmd;
         cin_d  = in_cin;
         have_d = in_inp_valid;
         opa_d  = in_inp_valid[0] ? in_opa : {WIDTH{1'b0}};
         opb_d  = in_inp_valid[1] ? in_opb : {WIDTH{1'b0}};
      end else if (merge_s) begin
         cin_d  = in_cin;
         have_d = have_q | in_inp_valid;
         opa_d  = in_inp_valid[0] ? in_opa : opa_q;
         opb_d  = in_inp_valid[1] ? in_opb : opb_q;
      end else begin
         have_d = have_q;
      end
   end

   always_comb begin
      need_s     = op_needs(mode_d, cmd_d);
      complete_s = ((have_d & need_s) == need_s);
      state_d    = state_q;
      iss_load_s = 1'b0;
      iss_mask_s = have_d & need_s;
      if (start_s | merge_s) begin
         if (complete_s) begin
            state_d    = ISSUE;
            iss_load_s = 1'b1;
         end else begin
            state_d    = WAIT;
            iss_load_s = 1'b0;
         end
      end else if (partial_s) begin
         state_d    = ISSUE;
         iss_load_s = 1'b1;
         iss_mask_s = have_d;
      end else if (go_idle_s) begin
         state_d = IDLE;
      end else begin
         state_d = state_q;
      end
   end

`ifdef ALU_COLLECT_TIMEOUT_EN
   logic tmr_clear_s, tmr_tick_s, timeout_q;

   // In WAIT every effective beat is either a merge or a restart, both of which reset the count.
   assign tmr_clear_s = (state_q != WAIT) | beat_s;
   assign tmr_tick_s  = (state_q == WAIT) & ~beat_s;

   alu_collect_timer #(
      .CYCLES    (TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (tmr_clear_s),
      .tick_i    (tmr_tick_s),
      .expired_o (expired_s)
   );

   always_ff @(posedge clk) begin
      if (!rst) timeout_q <= 1'b0;
      else      timeout_q <= partial_s;
   end

   assign timeout = timeout_q;
`else
   assign expired_s = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         mode_q     <= 1'b0;
         cmd_q      <= 4'd0;
         cin_q      <= 1'b0;
         have_q     <= 2'b00;
         opa_q      <= {WIDTH{1'b0}};
         opb_q      <= {WIDTH{1'b0}};
         ce_q       <= 1'b0;
         busy_q     <= 1'b0;
         drop_q     <= 1'b0;
         iss_mode_q <= 1'b0;
         iss_cmd_q  <= 4'd0;
         iss_cin_q  <= 1'b0;
         iss_vld_q  <= 2'b00;
         iss_opa_q  <= {WIDTH{1'b0}};
         iss_opb_q  <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cmd_q   <= cmd_d;
         cin_q   <= cin_d;
         have_q  <= have_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         ce_q    <= (state_d == ISSUE);
         busy_q  <= (state_d != IDLE);
         drop_q  <= drop_d;
         if (iss_load_s) begin
            iss_mode_q <= mode_d;
            iss_cmd_q  <= cmd_d;
            iss_cin_q  <= cin_d;
            iss_vld_q  <= iss_mask_s;
            iss_opa_q  <= iss_mask_s[0] ? opa_d : {WIDTH{1'b0}};
            iss_opb_q  <= iss_mask_s[1] ? opb_d : {WIDTH{1'b0}};
         end
      end
   end

   assign alu_ce        = ce_q;
   assign alu_mode      = iss_mode_q;
   assign alu_cmd       = iss_cmd_q;
   assign alu_cin       = iss_cin_q;
   assign alu_inp_valid = iss_vld_q;
   assign alu_opa       = iss_opa_q;
   assign alu_opb       = iss_opb_q;
   assign drop          = drop_q;
   assign busy          = busy_q;

endmodule
